// File: rtl/bus_width_decrease_pkt.sv
// Wide-to-narrow stream width converter with partial final words, packet-end marking and
// selectable slice order. One narrow beat per cycle, including across word boundaries.
module bus_width_decrease_pkt #(
  parameter int unsigned SIZE_IN       = 32,
  parameter int unsigned SIZE_OUT      = 8,
  parameter bit          LITTLE_ENDIAN = 1'b1,
  localparam int unsigned RATIO        = SIZE_IN / SIZE_OUT,
  localparam int unsigned CW           = $clog2(RATIO + 1),
  localparam int unsigned IW           = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic [SIZE_IN-1:0]  data_in,
  input  logic [CW-1:0]       in_beats,
  input  logic                in_last,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [SIZE_OUT-1:0] data_out,
  output logic                out_last,
  output logic                busy
);

  if ((SIZE_IN % SIZE_OUT) != 0) begin : g_size_check
    $error("SIZE_IN must be an integer multiple of SIZE_OUT");
  end

  logic [SIZE_IN-1:0] hold_q;
  logic [CW-1:0]      remaining_q, remaining_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               last_flag_q, last_flag_d;
  logic [CW-1:0]      n_eff;
  logic               accept, out_fire;

  // Zero or an oversize count means a full word.
  always_comb begin
    n_eff = in_beats;
    if ((in_beats == '0) || (in_beats > CW'(RATIO))) begin
      n_eff = CW'(RATIO);
    end
  end

  assign output_valid = (remaining_q != '0);
  assign busy         = output_valid;
  assign out_last     = last_flag_q & (remaining_q == CW'(1));
  // Combinational path from output_ready lets a new word load as the last slice leaves.
  assign input_ready  = (remaining_q == '0) | ((remaining_q == CW'(1)) & output_ready);
  assign accept       = input_valid & input_ready;
  assign out_fire     = output_valid & output_ready;

  always_comb begin
    data_out = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (idx_q == IW'(i)) data_out = hold_q[i*SIZE_OUT +: SIZE_OUT];
    end
  end

  // Accept takes priority so a retiring word and an incoming word share one edge.
  always_comb begin
    remaining_d = remaining_q;
    idx_d       = idx_q;
    last_flag_d = last_flag_q;
    if (accept) begin
      remaining_d = n_eff;
      last_flag_d = in_last;
      idx_d       = LITTLE_ENDIAN ? '0 : IW'(RATIO - 1);
    end else if (out_fire) begin
      remaining_d = remaining_q - CW'(1);
      idx_d       = LITTLE_ENDIAN ? idx_q + IW'(1) : idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      idx_q       <= '0;
      last_flag_q <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      last_flag_q <= last_flag_d;
    end
  end

  // Data path is deliberately left unreset; it is only observed while output_valid is high.
  always_ff @(posedge clk) begin
    if (accept) hold_q <= data_in;
  end

endmodule

// File: tb/tb_bus_width_decrease_pkt.sv
// Directed bench for bus_width_decrease_pkt: little- and big-endian instances driven in parallel
// with shared stimulus, each scenario checked against hand-computed slice sequences.
module tb_bus_width_decrease_pkt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic [31:0] din;
  logic [2:0]  beats;
  logic        ilast;
  logic        ordy;

  logic       ir_le, ov_le, ol_le, busy_le;
  logic [7:0] do_le;
  logic       ir_be, ov_be, ol_be, busy_be;
  logic [7:0] do_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_width_decrease_pkt #(.SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(1'b1)) u_le (
    .clk(clk), .rst_n(rst_n), .input_valid(iv), .input_ready(ir_le), .data_in(din),
    .in_beats(beats), .in_last(ilast), .output_valid(ov_le), .output_ready(ordy),
    .data_out(do_le), .out_last(ol_le), .busy(busy_le)
  );

  bus_width_decrease_pkt #(.SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(1'b0)) u_be (
    .clk(clk), .rst_n(rst_n), .input_valid(iv), .input_ready(ir_be), .data_in(din),
    .in_beats(beats), .in_last(ilast), .output_valid(ov_be), .output_ready(ordy),
    .data_out(do_be), .out_last(ol_be), .busy(busy_be)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single edge (both instances are idle, so it is accepted).
  task automatic load(input logic [31:0] d, input logic [2:0] b, input logic l);
    iv = 1'b1; din = d; beats = b; ilast = l; ordy = 1'b1;
    tick();
    iv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = 1'b0; din = '0; beats = '0; ilast = 1'b0; ordy = 1'b0;
    #3;
    n_checks++;
    if (ov_le !== 1'b0 || ov_be !== 1'b0)
      $display("FAIL reset_valid: got %b/%b want 0/0", ov_le, ov_be);
    else n_pass++;
    n_checks++;
    if (ir_le !== 1'b1 || ir_be !== 1'b1)
      $display("FAIL reset_ready: got %b/%b want 1/1", ir_le, ir_be);
    else n_pass++;
    n_checks++;
    if (busy_le !== 1'b0 || ol_le !== 1'b0 || busy_be !== 1'b0 || ol_be !== 1'b0)
      $display("FAIL reset_busy_last: got %b%b%b%b want 0000", busy_le, ol_le, busy_be, ol_be);
    else n_pass++;
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    logic [7:0] exp_le [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] exp_be [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    load(32'hDDCCBBAA, 3'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ov_le !== 1'b1 || do_le !== exp_le[k] || ol_le !== (k == 3))
        $display("FAIL full_le[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, ov_le, do_le, ol_le, exp_le[k], (k == 3));
      else n_pass++;
      n_checks++;
      if (ov_be !== 1'b1 || do_be !== exp_be[k] || ol_be !== (k == 3))
        $display("FAIL full_be[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, ov_be, do_be, ol_be, exp_be[k], (k == 3));
      else n_pass++;
      tick();
    end
    n_checks++;
    if (busy_le !== 1'b0 || busy_be !== 1'b0 || ov_le !== 1'b0)
      $display("FAIL full_idle: got busy=%b/%b v=%b want 0/0 0", busy_le, busy_be, ov_le);
    else n_pass++;
  endtask

  task automatic test_partial();
    logic [7:0] exp_le [2] = '{8'hAA, 8'hBB};
    logic [7:0] exp_be [2] = '{8'hDD, 8'hCC};
    load(32'hDDCCBBAA, 3'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ov_le !== 1'b1 || do_le !== exp_le[k] || ol_le !== (k == 1))
        $display("FAIL partial_le[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, ov_le, do_le, ol_le, exp_le[k], (k == 1));
      else n_pass++;
      n_checks++;
      if (ov_be !== 1'b1 || do_be !== exp_be[k] || ol_be !== (k == 1))
        $display("FAIL partial_be[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, ov_be, do_be, ol_be, exp_be[k], (k == 1));
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ov_le !== 1'b0 || ov_be !== 1'b0)
      $display("FAIL partial_idle: got v=%b/%b want 0/0", ov_le, ov_be);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    iv = 1'b1; din = 32'h03020100; beats = 3'd4; ilast = 1'b0; ordy = 1'b1;
    #1;
    n_checks++;
    if (ir_le !== 1'b1) $display("FAIL b2b_first_ready: got %b want 1", ir_le);
    else n_pass++;
    tick();
    for (int k = 1; k <= 8; k++) begin
      iv    = (k <= 4);
      din   = 32'h07060504;
      ilast = 1'b1;
      #1;
      n_checks++;
      if (ov_le !== 1'b1 || do_le !== 8'(k - 1) || ir_le !== (k == 4 || k == 8) ||
          ol_le !== (k == 8))
        $display("FAIL b2b[%0d]: got v=%b d=%h r=%b l=%b want v=1 d=%h r=%b l=%b",
                 k, ov_le, do_le, ir_le, ol_le, 8'(k - 1), (k == 4 || k == 8), (k == 8));
      else n_pass++;
      tick();
    end
    iv = 1'b0;
    n_checks++;
    if (ov_le !== 1'b0) $display("FAIL b2b_idle: got v=%b want 0", ov_le);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic       pat    [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_le [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int ptr = 0;
    int cyc = 0;
    load(32'hDDCCBBAA, 3'd0, 1'b1);
    while (ptr < 4 && cyc < 20) begin
      ordy = pat[cyc % 8];
      #1;
      n_checks++;
      if (ov_le !== 1'b1 || do_le !== exp_le[ptr] || ir_le !== (ordy && ptr == 3))
        $display("FAIL stall[%0d]: got v=%b d=%h r=%b want v=1 d=%h r=%b",
                 cyc, ov_le, do_le, ir_le, exp_le[ptr], (ordy && ptr == 3));
      else n_pass++;
      if (ordy) ptr++;
      cyc++;
      tick();
    end
    n_checks++;
    if (ptr != 4 || ov_le !== 1'b0)
      $display("FAIL stall_done: got slices=%0d v=%b want 4 0", ptr, ov_le);
    else n_pass++;
    ordy = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_le [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_be [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    load(32'hDDCCBBAA, 3'd0, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov_le !== 1'b0 || ir_le !== 1'b1 || ov_be !== 1'b0 || ir_be !== 1'b1 || busy_le !== 1'b0)
      $display("FAIL rst_mid: got v=%b/%b r=%b/%b busy=%b want v=0/0 r=1/1 busy=0",
               ov_le, ov_be, ir_le, ir_be, busy_le);
    else n_pass++;
    #2 rst_n = 1'b1;
    tick();
    load(32'h44332211, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ov_le !== 1'b1 || do_le !== exp_le[k] || ol_le !== 1'b0)
        $display("FAIL post_rst_le[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=0",
                 k, ov_le, do_le, ol_le, exp_le[k]);
      else n_pass++;
      n_checks++;
      if (ov_be !== 1'b1 || do_be !== exp_be[k])
        $display("FAIL post_rst_be[%0d]: got v=%b d=%h want v=1 d=%h", k, ov_be, do_be, exp_be[k]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ov_le !== 1'b0 || ov_be !== 1'b0)
      $display("FAIL post_rst_idle: got v=%b/%b want 0/0", ov_le, ov_be);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_width_decrease_pkt.md
# bus_width_decrease_pkt

- Wide-to-narrow bus width converter for packetised streams; a parametrised successor to the basic width-decrease stage.
- Adds partial final words (a per-word beat count), packet-end propagation, selectable slice order and asynchronous active-low reset.
- Sustains one narrow beat per cycle, including across word boundaries with no bubble.
- Sits between a wide producer (DMA or FIFO read side) and a narrow consumer (serializer or narrow FIFO).

## Interface
Parameters:
- SIZE_IN, 32, input bus width in bits; must be an integer multiple of SIZE_OUT (elaboration error otherwise).
- SIZE_OUT, 8, output bus width in bits.
- LITTLE_ENDIAN, 1, 1: slice [SIZE_OUT-1:0] is emitted first; 0: the most-significant slice is emitted first.
- Derived: RATIO = SIZE_IN/SIZE_OUT; CW = $clog2(RATIO+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- input_valid  in  1  producer has a word.
- input_ready  out  1  block accepts a word this cycle.
- data_in  in  SIZE_IN  wide word.
- in_beats  in  CW  number of valid narrow slices in data_in. 0 or values above RATIO mean RATIO.
- in_last  in  1  word ends a packet.
- output_valid  out  1  data_out holds a valid slice.
- output_ready  in  1  consumer takes the slice.
- data_out  out  SIZE_OUT  current slice.
- out_last  out  1  current slice is the final slice of a word accepted with in_last=1.
- busy  out  1  holding register not empty (remaining != 0).

## Operation
- State:
  - hold register, SIZE_IN bits.
  - remaining, CW bits: number of slices still to emit.
  - idx: slice index of the current slice.
  - last_flag.
- Input accept: a word is accepted when input_valid & input_ready. On accept:
  - hold <= data_in.
  - remaining <= effective beats n.
  - last_flag <= in_last.
  - idx <= 0 (LE) or RATIO-1 (BE).
- Slice order:
  - LE emits slices 0, 1, … n-1.
  - BE emits slices RATIO-1 down to RATIO-n.
  - Slices outside the first n are never emitted.
- Output:
  - output_valid = (remaining != 0).
  - data_out = hold[idx*SIZE_OUT +: SIZE_OUT].
  - out_last = last_flag & (remaining == 1).
- Output handshake: when output_valid & output_ready, and no accept happens in the same cycle:
  - remaining decrements.
  - idx steps by +1 (LE) or -1 (BE).
- input_ready = (remaining == 0) | (remaining == 1 & output_ready). This is a combinational path from output_ready to input_ready, and it is intentional.
- Simultaneous final-slice handshake and accept: the accept wins. The new word loads and the old word is retired in the same edge.
- Consumer stall: hold, remaining, idx and all outputs hold steady while output_valid & ~output_ready. data_out must not change while stalled.
- RATIO == 1:
  - Behaves as a single-entry register slice with in_beats ignored (n=1).
  - out_last = last_flag.
- Reset: rst_n low at any time, including mid-word:
  - remaining=0, idx=0, last_flag=0.
  - output_valid=0, out_last=0, busy=0, input_ready=1.
  - data_out is don't-care (hold is not reset).
  - A partially emitted word is discarded.

## Timing
- Latency: word accepted at edge k → first slice has output_valid=1 in the cycle after edge k.
- Throughput: with output_ready held high and input_valid held high, exactly one slice per cycle and no idle cycle between words.
- Per-word cycles (with output_ready held high) = n.
- input_valid is never qualified by output_valid. input_ready does not depend on input_valid.
- Reset assertion takes effect immediately (asynchronous). The first accept is possible at the first rising edge after rst_n deasserts.

## Test plan
- Reset, then RATIO=4 LE, data_in=32'hDDCCBBAA, in_beats=0, in_last=1, output_ready=1 → data_out AA, BB, CC, DD on four consecutive cycles; out_last=1 only on DD; busy low afterwards.
- LITTLE_ENDIAN=0, same word → DD, CC, BB, AA.
- Partial word, in_beats=2, in_last=1:
  - LE → AA, BB with out_last on BB.
  - BE → DD, CC with out_last on CC.
- Back-to-back words 32'h03020100 then 32'h07060504, both in_beats=4, input_valid and output_ready held high → 00..07 on eight consecutive cycles; input_ready high exactly in the accept cycles.
- output_ready toggled 1,0,0,1,… on a full word → data_out stable through every stall; no slice dropped or duplicated; input_ready low until the final slice is consumed.
- rst_n pulsed low after two of four slices → output_valid=0 and input_ready=1 immediately. After release, a new word 32'h44332211 emits 11, 22, 33, 44 with no remnant of the old word.
